mcrp_sequencer: RTL and testbench



---
 rtl/mcrp_pkg.sv | 52 +++++
 rtl/mcrp_sequencer_if.sv | 32 +++
 rtl/mcrp_wait_timer.sv | 35 +++
 rtl/mcrp_sequencer.sv | 169 ++++++++++++++++
 tb/tb_mcrp_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcrp_pkg.sv
// mcrp_pkg: shared encodings for the MCRP multi-cycle sequencer
// (state codes, instruction type codes, opcode constants, pc_src encodings,
// per-type opcode legality).
package mcrp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_IF   = 3'd1,
      ST_ID   = 3'd2,
      ST_EX   = 3'd3,
      ST_MEM  = 3'd4,
      ST_WB   = 3'd5,
      ST_ERR  = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      TY_R = 2'b00,
      TY_I = 2'b01,
      TY_J = 2'b10,
      TY_S = 2'b11
   } itype_t;

   localparam logic [4:0] OP_CMP = 5'd3;   // R-type
   localparam logic [4:0] OP_LW  = 5'd2;   // I-type
   localparam logic [4:0] OP_SW  = 5'd3;   // I-type
   localparam logic [4:0] OP_BEQ = 5'd4;   // I-type
   localparam logic [4:0] OP_JAL = 5'd1;   // J-type

   localparam logic [1:0] PC_SRC_INC = 2'b00;
   localparam logic [1:0] PC_SRC_BTA = 2'b01;
   localparam logic [1:0] PC_SRC_JA  = 2'b10;
   localparam logic [1:0] PC_SRC_RA  = 2'b11;

   localparam logic [4:0] MAX_OP_R = 5'd3;
   localparam logic [4:0] MAX_OP_I = 5'd4;
   localparam logic [4:0] MAX_OP_J = 5'd1;
   localparam logic [4:0] MAX_OP_S = 5'd3;

   function automatic logic [4:0] max_legal_op(input itype_t t);
      case (t)
         TY_R:    return MAX_OP_R;
         TY_I:    return MAX_OP_I;
         TY_J:    return MAX_OP_J;
         default: return MAX_OP_S;
      endcase
   endfunction

   function automatic logic op_legal(input itype_t t, input logic [4:0] op);
      return (op <= max_legal_op(t));
   endfunction

endpackage

// File: rtl/mcrp_sequencer_if.sv
// mcrp_sequencer_if: datapath <-> sequencer bundle. The datapath side (master)
// drives run/ir/zero/mem_ack; the sequencer side (slave) drives the strobes.
interface mcrp_sequencer_if #(parameter int CNT_W = 32);
   logic             run;
   logic [31:0]      ir;
   logic             zero;
   logic             mem_ack;
   logic [2:0]       state_out;
   logic             ir_write;
   logic             pc_write;
   logic [1:0]       pc_src;
   logic             reg_write;
   logic             wb_src;
   logic             mem_read;
   logic             mem_write;
   logic             stack_push;
   logic             stack_pop;
   logic             fault;
   logic [CNT_W-1:0] retired;

   modport master (
      output run, ir, zero, mem_ack,
      input  state_out, ir_write, pc_write, pc_src, reg_write, wb_src,
             mem_read, mem_write, stack_push, stack_pop, fault, retired
   );

   modport slave (
      input  run, ir, zero, mem_ack,
      output state_out, ir_write, pc_write, pc_src, reg_write, wb_src,
             mem_read, mem_write, stack_push, stack_pop, fault, retired
   );
endinterface

// File: rtl/mcrp_wait_timer.sv
// mcrp_wait_timer: counts consecutive unacked MEM cycles; expired is high in
// the MAX_WAIT-th unacked cycle so the FSM leaves MEM for ERR on that edge.
// Only built when MCRP_MEM_WAIT_EN is defined.
module mcrp_wait_timer #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired = en && (cnt_q == CW'(MAX_WAIT - 1));

   // Next count: restart on MEM entry, advance on each unacked MEM cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && !expired)
         cnt_d = cnt_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/mcrp_sequencer.sv
// mcrp_sequencer: clocked multi-cycle FSM (IDLE/IF/ID/EX/MEM/WB/ERR) that
// decides when PC, IR, register file, data memory and stack are written.
// Optional build macro MCRP_MEM_WAIT_EN: MEM waits for mem_ack with a
// MAX_WAIT-cycle timeout to ERR; otherwise MEM is a single cycle.
module mcrp_sequencer
   import mcrp_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 15,
   parameter int          CNT_W    = 32
) (
   input  logic               clk,
   input  logic               reset,
   mcrp_sequencer_if.slave    bus
);
   state_t           state_q, state_d;
   logic [4:0]       op_q, op_d;
   itype_t           typ_q, typ_d;
   logic             stop_q, stop_d;
   logic             fault_q, fault_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic op_ok, is_lw, is_sw, is_beq, is_cmp, is_jal;
   logic mem_done, mem_expired, instr_end;

   logic       ir_write, pc_write, reg_write, wb_src;
   logic       mem_read, mem_write, stack_push, stack_pop;
   logic [1:0] pc_src;

   logic unused_ir_bits;
   assign unused_ir_bits = ^bus.ir[26:3];

`ifdef MCRP_MEM_WAIT_EN
   assign mem_done = bus.mem_ack;

   mcrp_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     ((state_d == ST_MEM) && (state_q != ST_MEM)),
      .en      ((state_q == ST_MEM) && !bus.mem_ack),
      .expired (mem_expired)
   );
`else
   localparam int unsigned UNUSED_MAX_WAIT = MAX_WAIT;
   logic unused_mem_ack;
   assign unused_mem_ack = bus.mem_ack;
   assign mem_done       = 1'b1;
   assign mem_expired    = 1'b0;
`endif

   assign op_ok  = op_legal(typ_q, op_q);
   assign is_lw  = (typ_q == TY_I) && (op_q == OP_LW);
   assign is_sw  = (typ_q == TY_I) && (op_q == OP_SW);
   assign is_beq = (typ_q == TY_I) && (op_q == OP_BEQ);
   assign is_cmp = (typ_q == TY_R) && (op_q == OP_CMP);
   assign is_jal = (typ_q == TY_J) && (op_q == OP_JAL);

   // Last-state cycle of the current instruction: the PC is written and the
   // instruction retires here.
   assign instr_end = ((state_q == ST_ID)  && (typ_q == TY_J) && op_ok) ||
                      ((state_q == ST_EX)  && (is_cmp || is_beq))       ||
                      ((state_q == ST_MEM) && is_sw && mem_done)        ||
                      (state_q == ST_WB);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.run) state_d = ST_IF;
         ST_IF:   state_d = ST_ID;
         ST_ID: begin
            if (!op_ok)
               state_d = ST_ERR;
            else if (typ_q != TY_J)
               state_d = ST_EX;
         end
         ST_EX: begin
            if (is_lw || is_sw)
               state_d = ST_MEM;
            else
               state_d = ST_WB;
         end
         ST_MEM: begin
            if (mem_done && is_lw)
               state_d = ST_WB;
            else if (!mem_done && mem_expired)
               state_d = ST_ERR;
         end
         ST_ERR:  state_d = ST_ERR;
         default: state_d = state_q;
      endcase
      if (instr_end)
         state_d = bus.run ? ST_IF : ST_IDLE;
   end

   // Next values of the latched instruction fields, fault flag and counter.
   always_comb begin
      op_d      = op_q;
      typ_d     = typ_q;
      stop_d    = stop_q;
      if (state_q == ST_IF) begin
         op_d   = bus.ir[31:27];
         typ_d  = itype_t'(bus.ir[2:1]);
         stop_d = bus.ir[0];
      end
      fault_d   = fault_q || (state_d == ST_ERR);
      retired_d = retired_q + CNT_W'(instr_end);
   end

   // Instruction fields, sticky fault and retired counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q      <= '0;
         typ_q     <= TY_R;
         stop_q    <= 1'b0;
         fault_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         op_q      <= op_d;
         typ_q     <= typ_d;
         stop_q    <= stop_d;
         fault_q   <= fault_d;
         retired_q <= retired_d;
      end
   end

   // Strobe decode from the state register and latched fields.
   always_comb begin
      ir_write   = (state_q == ST_IF);
      pc_write   = instr_end;
      pc_src     = PC_SRC_INC;
      stack_pop  = 1'b0;
      stack_push = (state_q == ST_ID) && is_jal;
      mem_read   = (state_q == ST_MEM) && is_lw;
      mem_write  = (state_q == ST_MEM) && is_sw;
      reg_write  = (state_q == ST_WB);
      wb_src     = (state_q == ST_WB) && is_lw;
      if (instr_end) begin
         if (typ_q == TY_J)
            pc_src = PC_SRC_JA;
         else if (is_beq && bus.zero)
            pc_src = PC_SRC_BTA;
         else if (stop_q) begin
            pc_src    = PC_SRC_RA;
            stack_pop = 1'b1;
         end
      end
   end

   assign bus.state_out  = state_q;
   assign bus.ir_write   = ir_write;
   assign bus.pc_write   = pc_write;
   assign bus.pc_src     = pc_src;
   assign bus.reg_write  = reg_write;
   assign bus.wb_src     = wb_src;
   assign bus.mem_read   = mem_read;
   assign bus.mem_write  = mem_write;
   assign bus.stack_push = stack_push;
   assign bus.stack_pop  = stack_pop;
   assign bus.fault      = fault_q;
   assign bus.retired    = retired_q;
endmodule

// File: tb/tb_mcrp_sequencer.sv
// tb_mcrp_sequencer: directed-vector bench for mcrp_sequencer. MEM-wait
// scenarios follow the MCRP_MEM_WAIT_EN build macro.
module tb_mcrp_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   mcrp_sequencer_if #(.CNT_W(32)) bus();

   mcrp_sequencer #(.MAX_WAIT(15), .CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // {state, ir_write, pc_write, pc_src, reg_write, wb_src, mem_read,
   //  mem_write, stack_push, stack_pop, fault}
   function automatic logic [13:0] obs();
      return {bus.state_out, bus.ir_write, bus.pc_write, bus.pc_src,
              bus.reg_write, bus.wb_src, bus.mem_read, bus.mem_write,
              bus.stack_push, bus.stack_pop, bus.fault};
   endfunction

   function automatic logic [13:0] pk(input logic [2:0] st, input logic irw,
         input logic pcw, input logic [1:0] src, input logic rw, input logic wbs,
         input logic mr, input logic mw, input logic psh, input logic pop,
         input logic flt);
      return {st, irw, pcw, src, rw, wbs, mr, mw, psh, pop, flt};
   endfunction

   function automatic logic [31:0] mk(input logic [1:0] t, input logic [4:0] op,
                                      input logic stop);
      return {op, 24'h0, t, stop};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.run = 1'b0;
      bus.ir = '0;
      bus.zero = 1'b0;
      bus.mem_ack = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      bus.run = 1'b1;
      bus.ir = mk(2'b00, 5'd1, 1'b0);
      bus.zero = 1'b0;
      bus.mem_ack = 1'b0;
      #1 reset = 1'b1;
      #1;
      vectors++;
      if (obs() !== 14'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h, expected %h", obs(), 14'h0);
      end
      vectors++;
      if (bus.retired !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_retired: got %0d, expected 0", bus.retired);
      end
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (obs() !== 14'h0) begin
            miscompares++;
            $display("FAIL idle_hold cycle %0d: got %h, expected %h", i, obs(), 14'h0);
         end
      end
   endtask

   task automatic test_add_back_to_back();
      logic [13:0] ex1 [5];
      logic [13:0] ex2 [4];
      ex1 = '{pk(1,1,0,0,0,0,0,0,0,0,0), pk(2,0,0,0,0,0,0,0,0,0,0),
              pk(3,0,0,0,0,0,0,0,0,0,0), pk(5,0,1,0,1,0,0,0,0,0,0),
              pk(1,1,0,0,0,0,0,0,0,0,0)};
      ex2 = '{pk(2,0,0,0,0,0,0,0,0,0,0), pk(3,0,0,0,0,0,0,0,0,0,0),
              pk(5,0,1,0,1,0,0,0,0,0,0), pk(0,0,0,0,0,0,0,0,0,0,0)};
      do_reset();
      bus.ir = mk(2'b00, 5'd1, 1'b0);
      bus.run = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         vectors++;
         if (obs() !== ex1[i]) begin
            miscompares++;
            $display("FAIL add cycle %0d: got %h, expected %h", i, obs(), ex1[i]);
         end
      end
      vectors++;
      if (bus.retired !== 32'd1) begin
         miscompares++;
         $display("FAIL add_retired1: got %0d, expected 1", bus.retired);
      end
      bus.run = 1'b0;  // dropped inside the second ADD; it must still finish
      for (int i = 0; i < 4; i++) begin
         step();
         vectors++;
         if (obs() !== ex2[i]) begin
            miscompares++;
            $display("FAIL add2 cycle %0d: got %h, expected %h", i, obs(), ex2[i]);
         end
      end
      vectors++;
      if (bus.retired !== 32'd2) begin
         miscompares++;
         $display("FAIL add_retired2: got %0d, expected 2", bus.retired);
      end
   endtask

   task automatic test_end_cases();
      logic [31:0] t_ir   [11];
      logic        t_z    [11];
      int          t_n    [11];
      logic [13:0] t_last [11];
      logic [13:0] e;
      t_ir   = '{mk(0,1,1), mk(0,3,0), mk(1,4,0), mk(1,4,0), mk(1,4,1), mk(1,4,1),
                 mk(2,1,0), mk(2,0,1), mk(1,1,0), mk(3,3,0), mk(0,0,0)};
      t_z    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      t_n    = '{4, 3, 3, 3, 3, 3, 2, 2, 4, 4, 4};
      t_last = '{pk(5,0,1,3,1,0,0,0,0,1,0),   // ADD stop -> RA + pop
                 pk(3,0,1,0,0,0,0,0,0,0,0),   // CMP
                 pk(3,0,1,1,0,0,0,0,0,0,0),   // BEQ taken
                 pk(3,0,1,0,0,0,0,0,0,0,0),   // BEQ not taken
                 pk(3,0,1,1,0,0,0,0,0,0,0),   // BEQ taken beats stop
                 pk(3,0,1,3,0,0,0,0,0,1,0),   // BEQ not taken, stop
                 pk(2,0,1,2,0,0,0,0,1,0,0),   // JAL
                 pk(2,0,1,2,0,0,0,0,0,0,0),   // J beats stop
                 pk(5,0,1,0,1,0,0,0,0,0,0),   // ADDI
                 pk(5,0,1,0,1,0,0,0,0,0,0),   // S op 3
                 pk(5,0,1,0,1,0,0,0,0,0,0)};  // R op 0, zero irrelevant
      for (int k = 0; k < 11; k++) begin
         do_reset();
         bus.zero = t_z[k];
         bus.ir = t_ir[k];
         bus.run = 1'b1;
         for (int c = 0; c < t_n[k]; c++) begin
            step();
            if (c == t_n[k] - 1) begin
               e = t_last[k];
               bus.run = 1'b0;
            end else if (c == 0)
               e = pk(1,1,0,0,0,0,0,0,0,0,0);
            else
               e = pk(3'(c + 1),0,0,0,0,0,0,0,0,0,0);
            vectors++;
            if (obs() !== e) begin
               miscompares++;
               $display("FAIL end_case %0d cycle %0d: got %h, expected %h", k, c, obs(), e);
            end
         end
         step();
         vectors++;
         if (obs() !== 14'h0 || bus.retired !== 32'd1) begin
            miscompares++;
            $display("FAIL end_case %0d idle: got %h/%0d, expected %h/1", k, obs(), bus.retired, 14'h0);
         end
      end
   endtask

   task automatic test_illegal();
      logic [31:0] bad [5];
      logic [13:0] ex  [4];
      bad = '{mk(0,7,0), mk(0,4,0), mk(1,5,0), mk(2,2,0), mk(3,4,0)};
      ex  = '{pk(1,1,0,0,0,0,0,0,0,0,0), pk(2,0,0,0,0,0,0,0,0,0,0),
              pk(6,0,0,0,0,0,0,0,0,0,1), pk(6,0,0,0,0,0,0,0,0,0,1)};
      for (int k = 0; k < 5; k++) begin
         do_reset();
         bus.ir = bad[k];
         bus.run = 1'b1;
         for (int c = 0; c < 4; c++) begin
            step();
            vectors++;
            if (obs() !== ex[c]) begin
               miscompares++;
               $display("FAIL illegal %0d cycle %0d: got %h, expected %h", k, c, obs(), ex[c]);
            end
         end
         vectors++;
         if (bus.retired !== 32'd0) begin
            miscompares++;
            $display("FAIL illegal %0d retired: got %0d, expected 0", k, bus.retired);
         end
      end
   endtask

`ifdef MCRP_MEM_WAIT_EN
   task automatic test_mem();
      logic [13:0] e;
      // LW, ack raised in the 4th MEM cycle: 8 cycles total.
      do_reset();
      bus.ir = mk(1,2,0);
      bus.run = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         if (c == 0)      e = pk(1,1,0,0,0,0,0,0,0,0,0);
         else if (c < 3)  e = pk(3'(c + 1),0,0,0,0,0,0,0,0,0,0);
         else if (c < 7)  e = pk(4,0,0,0,0,0,1,0,0,0,0);
         else             e = pk(5,0,1,0,1,1,0,0,0,0,0);
         vectors++;
         if (obs() !== e) begin
            miscompares++;
            $display("FAIL lw_wait cycle %0d: got %h, expected %h", c, obs(), e);
         end
         if (c == 6) bus.mem_ack = 1'b1;
         if (c == 7) begin
            bus.mem_ack = 1'b0;
            bus.run = 1'b0;
         end
      end
      step();
      vectors++;
      if (obs() !== 14'h0 || bus.retired !== 32'd1) begin
         miscompares++;
         $display("FAIL lw_wait idle: got %h/%0d, expected %h/1", obs(), bus.retired, 14'h0);
      end
      // SW with no ack: 15 MEM cycles then ERR.
      do_reset();
      bus.ir = mk(1,3,0);
      bus.run = 1'b1;
      for (int c = 0; c < 22; c++) begin
         step();
         if (c == 0)      e = pk(1,1,0,0,0,0,0,0,0,0,0);
         else if (c < 3)  e = pk(3'(c + 1),0,0,0,0,0,0,0,0,0,0);
         else if (c < 18) e = pk(4,0,0,0,0,0,0,1,0,0,0);
         else             e = pk(6,0,0,0,0,0,0,0,0,0,1);
         vectors++;
         if (obs() !== e) begin
            miscompares++;
            $display("FAIL sw_timeout cycle %0d: got %h, expected %h", c, obs(), e);
         end
      end
      vectors++;
      if (bus.retired !== 32'd0) begin
         miscompares++;
         $display("FAIL sw_timeout retired: got %0d, expected 0", bus.retired);
      end
   endtask
`else
   task automatic test_mem();
      logic [13:0] lw_ex [6];
      logic [13:0] sw_ex [5];
      lw_ex = '{pk(1,1,0,0,0,0,0,0,0,0,0), pk(2,0,0,0,0,0,0,0,0,0,0),
                pk(3,0,0,0,0,0,0,0,0,0,0), pk(4,0,0,0,0,0,1,0,0,0,0),
                pk(5,0,1,0,1,1,0,0,0,0,0), pk(0,0,0,0,0,0,0,0,0,0,0)};
      sw_ex = '{pk(1,1,0,0,0,0,0,0,0,0,0), pk(2,0,0,0,0,0,0,0,0,0,0),
                pk(3,0,0,0,0,0,0,0,0,0,0), pk(4,0,1,0,0,0,0,1,0,0,0),
                pk(0,0,0,0,0,0,0,0,0,0,0)};
      do_reset();
      bus.ir = mk(1,2,0);
      bus.run = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         vectors++;
         if (obs() !== lw_ex[c]) begin
            miscompares++;
            $display("FAIL lw cycle %0d: got %h, expected %h", c, obs(), lw_ex[c]);
         end
         if (c == 4) bus.run = 1'b0;
      end
      do_reset();
      bus.ir = mk(1,3,0);
      bus.run = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         vectors++;
         if (obs() !== sw_ex[c]) begin
            miscompares++;
            $display("FAIL sw cycle %0d: got %h, expected %h", c, obs(), sw_ex[c]);
         end
         if (c == 3) bus.run = 1'b0;
      end
      vectors++;
      if (bus.retired !== 32'd1) begin
         miscompares++;
         $display("FAIL sw retired: got %0d, expected 1", bus.retired);
      end
   endtask
`endif

   task automatic test_reset_in_mem();
      do_reset();
      bus.ir = mk(0,1,0);
      bus.run = 1'b1;
      for (int c = 0; c < 4; c++) step();
      bus.ir = mk(1,2,0);
      for (int c = 0; c < 4; c++) step();
      vectors++;
      if (obs() !== pk(4,0,0,0,0,0,1,0,0,0,0) || bus.retired !== 32'd1) begin
         miscompares++;
         $display("FAIL pre_reset_mem: got %h/%0d, expected %h/1", obs(), bus.retired,
                  pk(4,0,0,0,0,0,1,0,0,0,0));
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (obs() !== 14'h0 || bus.retired !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_in_mem: got %h/%0d, expected %h/0", obs(), bus.retired, 14'h0);
      end
      step();
      bus.run = 1'b0;
      reset = 1'b0;
      step();
      vectors++;
      if (obs() !== 14'h0 || bus.retired !== 32'd0) begin
         miscompares++;
         $display("FAIL after_reset_in_mem: got %h/%0d, expected %h/0", obs(), bus.retired, 14'h0);
      end
   endtask

   initial begin
      test_reset();
      test_add_back_to_back();
      test_end_cases();
      test_illegal();
      test_mem();
      test_reset_in_mem();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
